// File: rtl/clock_gen_pkg.sv
// Shared mode encoding and helpers for the clock generator / mux.
package clock_gen_pkg;

  localparam int unsigned MODE_W = 2;

  // Active clock source encoding
  typedef enum logic [MODE_W-1:0] {
    MODE_DIV    = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_SEND   = 2'd2,
    MODE_RECV   = 2'd3
  } mode_e;

  // Mode request priority: manual beats send beats receive, else divider
  function automatic mode_e req_mode(input logic flag_in,
                                     input logic flag_send,
                                     input logic flag_recv);
    mode_e m;
    m = MODE_DIV;
    if (flag_in)        m = MODE_MANUAL;
    else if (flag_send) m = MODE_SEND;
    else if (flag_recv) m = MODE_RECV;
    return m;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, plus a registered
// one-cycle pulse on each synchronized rising edge. The pulse register is
// computed from the last two synchronizer taps so it lines up with the cycle
// in which the final stage first holds the new level.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rise_q;
  logic                   rise_d;

  // Shift the async level in; flag when the newest-but-one tap is high and the
  // final tap is still low (i.e. the final tap is about to rise)
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    rise_d = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge registers, cleared together so a level already high
  // after reset is seen as one fresh rise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/clock_gen_mux.sv
// Processor clock generator: free-running divider tap, or fixed-length
// pulses stepped by a manual button or one of two handshake lines.
module clock_gen_mux
  import clock_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned TAP_W       = 5,
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLOCK,
  input  logic              reset,
  input  logic              enter,
  input  logic              flagIN,
  input  logic              flagSend,
  input  logic              flagReceive,
  input  logic              send_confirmS,
  input  logic              send_confirmR,
  input  logic [TAP_W-1:0]  tap_sel,
  input  logic              halt,
  output logic              NEW_CLOCK,
  output logic              tick,
  output logic [MODE_W-1:0] mode
);

  localparam int unsigned PCNT_W = $clog2(PULSE_LEN + 1);
  localparam int unsigned IDX_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              nc_q,   nc_d;
  logic              tick_q, tick_d;
  mode_e             mode_q, mode_d;

  logic              rise_enter;
  logic              rise_send;
  logic              rise_recv;

  mode_e             req_c;
  logic              step_rise_c;
  logic              busy_c;
  logic [IDX_W-1:0]  tap_idx_c;

  // One synchronizer + edge detector per step source
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_enter (
    .clk_i   (CLOCK),
    .rst_i   (reset),
    .async_i (enter),
    .rise_o  (rise_enter)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_send (
    .clk_i   (CLOCK),
    .rst_i   (reset),
    .async_i (send_confirmS),
    .rise_o  (rise_send)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_recv (
    .clk_i   (CLOCK),
    .rst_i   (reset),
    .async_i (send_confirmR),
    .rise_o  (rise_recv)
  );

  // Out-of-range taps fall back to the counter MSB
  always_comb begin
    if (32'(tap_sel) >= CNT_W) tap_idx_c = IDX_W'(CNT_W - 1);
    else                       tap_idx_c = IDX_W'(tap_sel);
  end

  // Pick the step source that belongs to the active pulse mode
  always_comb begin
    step_rise_c = 1'b0;
    unique case (mode_q)
      MODE_MANUAL: step_rise_c = rise_enter;
      MODE_SEND:   step_rise_c = rise_send;
      MODE_RECV:   step_rise_c = rise_recv;
      default:     step_rise_c = 1'b0;
    endcase
  end

  // Next-state: mode switch only while the clock is low and idle, otherwise
  // run the divider or the pulse generator for the current mode
  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    pcnt_d = pcnt_q;
    nc_d   = 1'b0;
    req_c  = req_mode(flagIN, flagSend, flagReceive);
    busy_c = (pcnt_q != '0);

    if (!busy_c && !nc_q && (req_c != mode_q)) begin
      mode_d = req_c;
      if (req_c == MODE_DIV) cnt_d = '0;
    end else if (mode_q == MODE_DIV) begin
      if (!halt) begin
        nc_d  = cnt_q[tap_idx_c];
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (busy_c) begin
      // Pulse in flight: halt does not cut it short
      pcnt_d = pcnt_q - PCNT_W'(1);
      nc_d   = (pcnt_q > PCNT_W'(1));
    end else if (step_rise_c && !halt) begin
      pcnt_d = PCNT_W'(PULSE_LEN);
      nc_d   = 1'b1;
    end

    tick_d = nc_d & ~nc_q;
  end

  // State and output registers
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      mode_q <= MODE_DIV;
      cnt_q  <= '0;
      pcnt_q <= '0;
      nc_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      nc_q   <= nc_d;
      tick_q <= tick_d;
    end
  end

  assign NEW_CLOCK = nc_q;
  assign tick      = tick_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_clock_gen_mux.sv
// Bench for clock_gen_mux: directed scenarios plus a randomized run, all
// checked against an edge-numbered behavioural model.
module tb_clock_gen_mux;

  localparam int unsigned CNT_W       = 25;
  localparam int unsigned TAP_W       = 5;
  localparam int unsigned PULSE_LEN   = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic             CLOCK = 1'b0;
  logic             reset, enter, flagIN, flagSend, flagReceive;
  logic             send_confirmS, send_confirmR, halt;
  logic [TAP_W-1:0] tap_sel;
  logic             NEW_CLOCK, tick;
  logic [1:0]       mode;

  int checks = 0;
  int errors = 0;

  clock_gen_mux #(
    .CNT_W(CNT_W), .TAP_W(TAP_W), .PULSE_LEN(PULSE_LEN), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLOCK(CLOCK), .reset(reset), .enter(enter), .flagIN(flagIN),
    .flagSend(flagSend), .flagReceive(flagReceive),
    .send_confirmS(send_confirmS), .send_confirmR(send_confirmR),
    .tap_sel(tap_sel), .halt(halt),
    .NEW_CLOCK(NEW_CLOCK), .tick(tick), .mode(mode)
  );

  always #5 CLOCK = ~CLOCK;

  // ---------------- reference model ----------------
  // Edges are numbered; a pulse is described by the edge number where it ends.
  logic [CNT_W-1:0] m_cnt;
  logic [1:0]       m_mode;
  bit               m_nc, m_tick;
  longint           m_edge = 0;
  longint           m_pend = -1;
  bit               m_hist [3][SYNC_STAGES+1]; // [src][k] = sample k+1 edges ago

  function automatic void model_edge();
    bit     cur [3];
    bit     rise [3];
    int     req, tap;
    bit     busy, nc_new;
    cur[0] = enter; cur[1] = send_confirmS; cur[2] = send_confirmR;
    m_edge++;
    if (reset) begin
      m_cnt = '0; m_mode = 2'd0; m_nc = 0; m_tick = 0; m_pend = -1;
      for (int i = 0; i < 3; i++)
        for (int k = 0; k <= SYNC_STAGES; k++) m_hist[i][k] = 0;
      return;
    end
    // A source sampled high SYNC_STAGES edges ago after being low the edge before
    for (int i = 0; i < 3; i++)
      rise[i] = m_hist[i][SYNC_STAGES-1] && !m_hist[i][SYNC_STAGES];
    req  = flagIN ? 1 : flagSend ? 2 : flagReceive ? 3 : 0;
    tap  = (int'(tap_sel) >= CNT_W) ? CNT_W - 1 : int'(tap_sel);
    busy = (m_edge <= m_pend);
    nc_new = 0;
    if (!busy && !m_nc && req != int'(m_mode)) begin
      m_mode = 2'(req);
      if (req == 0) m_cnt = '0;
    end else if (m_mode == 2'd0) begin
      if (!halt) begin
        nc_new = m_cnt[tap];
        m_cnt  = m_cnt + 1'b1;
      end
    end else if (busy) begin
      nc_new = (m_edge < m_pend);
    end else if (rise[int'(m_mode) - 1] && !halt) begin
      nc_new = 1;
      m_pend = m_edge + longint'(PULSE_LEN);
    end
    m_tick = nc_new && !m_nc;
    m_nc   = nc_new;
    for (int i = 0; i < 3; i++) begin
      for (int k = SYNC_STAGES; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = cur[i];
    end
  endfunction

  // Advance one clock; model sees the inputs at the edge, outputs read 1 ns later
  task automatic clk_step();
    @(posedge CLOCK);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    enter = 0; flagIN = 0; flagSend = 0; flagReceive = 0;
    send_confirmS = 0; send_confirmR = 0; halt = 0; tap_sel = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    clk_step();
    clk_step();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    halt = 0; tap_sel = 5'd0; flagSend = 1; send_confirmS = 1;
    reset = 1;
    clk_step();
    checks++;
    if ({NEW_CLOCK, tick, mode} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got nc=%b tick=%b mode=%0d, need 0 0 0", NEW_CLOCK, tick, mode);
    end
    clk_step();
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_div_taps();
    int ticks, highs, last_t;
    // tap 0: period 2
    apply_reset();
    tap_sel = 5'd0;
    ticks = 0; last_t = -1;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      checks++;
      if ({NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL div_tap0_model i=%0d: got %b need %b", i, {NEW_CLOCK, tick, mode}, {m_nc, m_tick, m_mode});
      end
      if (tick) begin
        if (last_t >= 0) begin
          checks++;
          if (i - last_t != 2) begin
            errors++;
            $display("FAIL div_tap0_period: got %0d need 2", i - last_t);
          end
        end
        last_t = i; ticks++;
      end
    end
    checks++;
    if (ticks != 10) begin
      errors++;
      $display("FAIL div_tap0_ticks: got %0d need 10", ticks);
    end
    // tap 3: period 16, 8 high
    apply_reset();
    tap_sel = 5'd3;
    ticks = 0; highs = 0; last_t = -1;
    for (int i = 0; i < 64; i++) begin
      clk_step();
      checks++;
      if ({NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL div_tap3_model i=%0d: got %b need %b", i, {NEW_CLOCK, tick, mode}, {m_nc, m_tick, m_mode});
      end
      if (NEW_CLOCK) highs++;
      if (tick) begin
        if (last_t >= 0) begin
          checks++;
          if (i - last_t != 16) begin
            errors++;
            $display("FAIL div_tap3_period: got %0d need 16", i - last_t);
          end
        end
        last_t = i; ticks++;
      end
    end
    checks++;
    if (ticks != 4 || highs != 32) begin
      errors++;
      $display("FAIL div_tap3_shape: got ticks=%0d highs=%0d need 4 32", ticks, highs);
    end
    // tap 31 clamps to 24: nothing toggles within a short window
    apply_reset();
    tap_sel = 5'd31;
    for (int i = 0; i < 40; i++) begin
      clk_step();
      checks++;
      if (NEW_CLOCK !== 1'b0 || NEW_CLOCK !== m_nc) begin
        errors++;
        $display("FAIL div_tap31 i=%0d: got %b need 0", i, NEW_CLOCK);
      end
    end
  endtask

  task automatic test_manual();
    int first_hi, highs, ticks;
    apply_reset();
    flagIN = 1;
    clk_step();
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL manual_mode: got %0d need 1", mode);
    end
    enter = 1;
    first_hi = -1; highs = 0; ticks = 0;
    for (int i = 0; i < 16; i++) begin
      clk_step();
      if (i == 9) enter = 0;
      checks++;
      if ({NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL manual_model i=%0d: got %b need %b", i, {NEW_CLOCK, tick, mode}, {m_nc, m_tick, m_mode});
      end
      if (NEW_CLOCK) begin
        highs++;
        if (first_hi < 0) first_hi = i;
      end
      if (tick) ticks++;
    end
    checks++;
    if (first_hi != 2 || highs != 4 || ticks != 1 || mode !== 2'd1) begin
      errors++;
      $display("FAIL manual_pulse: got start=%0d highs=%0d ticks=%0d mode=%0d need 2 4 1 1",
               first_hi, highs, ticks, mode);
    end
  endtask

  task automatic test_back_to_back();
    logic pat [16];
    int   ticks;
    pat = '{1,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0};
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      enter = pat[i];
      clk_step();
      checks++;
      if ({NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL b2b_model i=%0d: got %b need %b", i, {NEW_CLOCK, tick, mode}, {m_nc, m_tick, m_mode});
      end
      if (tick) ticks++;
    end
    checks++;
    if (ticks != 1) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d need 1", ticks);
    end
    enter = 0;
  endtask

  task automatic test_mode_switch();
    int  run;
    bit  found;
    apply_reset();
    tap_sel = 5'd2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      clk_step();
      if (tick) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL switch_wait_tick: got no tick need one within 20 cycles");
    end
    flagSend = 1;
    run = 1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      clk_step();
      checks++;
      if ({NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL switch_model i=%0d: got %b need %b", i, {NEW_CLOCK, tick, mode}, {m_nc, m_tick, m_mode});
      end
      if (mode == 2'd2) found = 1;
      else if (NEW_CLOCK) run++;
    end
    checks++;
    if (!found || run != 4 || NEW_CLOCK !== 1'b0) begin
      errors++;
      $display("FAIL switch_result: got mode=%0d high_run=%0d nc=%b need 2 4 0", mode, run, NEW_CLOCK);
    end
    flagSend = 0;
  endtask

  task automatic test_halt();
    apply_reset();
    tap_sel = 5'd2;
    repeat (5) clk_step();
    halt = 1;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      checks++;
      if (NEW_CLOCK !== 1'b0 || {NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL halt_hold i=%0d: got nc=%b need 0", i, NEW_CLOCK);
      end
    end
    halt = 0;
    clk_step();
    checks++;
    if (NEW_CLOCK !== 1'b1 || tick !== 1'b1) begin
      errors++;
      $display("FAIL halt_resume: got nc=%b tick=%b need 1 1", NEW_CLOCK, tick);
    end
    for (int i = 0; i < 20; i++) begin
      clk_step();
      checks++;
      if ({NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL halt_model i=%0d: got %b need %b", i, {NEW_CLOCK, tick, mode}, {m_nc, m_tick, m_mode});
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit found;
    apply_reset();
    tap_sel = 5'd3;
    flagSend = 1;
    clk_step();
    send_confirmS = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      clk_step();
      if (tick) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midpulse_wait: got no pulse need one within 10 cycles");
    end
    clk_step();
    reset = 1; flagSend = 0; send_confirmS = 0;
    clk_step();
    checks++;
    if (NEW_CLOCK !== 1'b0 || mode !== 2'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL midpulse_reset: got nc=%b mode=%0d tick=%b need 0 0 0", NEW_CLOCK, mode, tick);
    end
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      clk_step();
      checks++;
      if (NEW_CLOCK !== 1'b0 || {NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL midpulse_residual i=%0d: got nc=%b need 0", i, NEW_CLOCK);
      end
    end
  endtask

  task automatic test_held_source();
    int ticks;
    clear_inputs();
    flagIN = 1; enter = 1; reset = 1;
    clk_step();
    clk_step();
    reset = 0;
    ticks = 0;
    for (int i = 0; i < 15; i++) begin
      clk_step();
      checks++;
      if ({NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL held_model i=%0d: got %b need %b", i, {NEW_CLOCK, tick, mode}, {m_nc, m_tick, m_mode});
      end
      if (tick) ticks++;
    end
    checks++;
    if (ticks != 1) begin
      errors++;
      $display("FAIL held_source: got %0d pulses need 1", ticks);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        flagIN      = ($urandom_range(0, 3) == 0);
        flagSend    = ($urandom_range(0, 2) == 0);
        flagReceive = ($urandom_range(0, 1) == 0);
      end
      if ($urandom_range(0, 49) == 0) tap_sel = TAP_W'($urandom_range(0, 31));
      else if ($urandom_range(0, 9) == 0) tap_sel = TAP_W'($urandom_range(0, 3));
      halt = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) enter         = ~enter;
      if ($urandom_range(0, 5) == 0) send_confirmS = ~send_confirmS;
      if ($urandom_range(0, 5) == 0) send_confirmR = ~send_confirmR;
      reset = ($urandom_range(0, 499) == 0);
      clk_step();
      checks++;
      if ({NEW_CLOCK, tick, mode} !== {m_nc, m_tick, m_mode}) begin
        errors++;
        $display("FAIL random_model i=%0d: got %b need %b", i, {NEW_CLOCK, tick, mode}, {m_nc, m_tick, m_mode});
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_div_taps();
    test_manual();
    test_back_to_back();
    test_mode_switch();
    test_halt();
    test_reset_mid_pulse();
    test_held_source();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
